// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared state type and default sizes for the I2S master clock controller
package i2s_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP} i2s_ctrl_state_t;

    localparam int I2S_FRAME_RES = 32;
    localparam int I2S_DIV_RES   = 8;

endpackage

// File: rtl/i2s_master_ctrl_module_clk_div.sv
// rtl/i2s_master_ctrl_module_clk_div.sv - half-period tick generator for the bit clock
module clk_div_module
    import i2s_pkg::*;
#(
    parameter int DIV_RES = I2S_DIV_RES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic [DIV_RES-1:0] div_i,
    output logic               tick_o
);

    logic [DIV_RES-1:0] r_hcnt;

    assign tick_o = ~clr_i & (r_hcnt == div_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hcnt <= '0;
        end else if (clr_i || tick_o) begin
            r_hcnt <= '0;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_master_ctrl_module.sv
// rtl/i2s_master_ctrl_module.sv - I2S bck/lrck master with frame-aligned start/stop
module i2s_master_ctrl_module
    import i2s_pkg::*;
#(
    parameter int FRAME_RES = I2S_FRAME_RES,
    parameter int DIV_RES   = I2S_DIV_RES,
    parameter int FCNT_RES  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [DIV_RES-1:0]  div_i,
    output logic                bck_o,
    output logic                lrck_o,
    output logic                bck_fall_o,
    output logic                frame_o,
    output logic                busy_o,
    output logic [FCNT_RES-1:0] frame_cnt_o
);

    localparam int BW = (FRAME_RES > 1) ? $clog2(FRAME_RES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_RES - 1);

    i2s_ctrl_state_t     r_state;
    logic [DIV_RES-1:0]  r_div_q;
    logic [BW-1:0]       r_bit_cnt;
    logic                r_bck;
    logic                r_lrck;
    logic                r_bck_fall;
    logic                r_frame;
    logic                r_busy;
    logic [FCNT_RES-1:0] r_frame_cnt;
    logic                w_tick;
    logic                w_clr;

    assign w_clr = (r_state == IDLE);

    clk_div_module #(
        .DIV_RES(DIV_RES)
    ) u_clk_div (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (w_clr),
        .div_i (r_div_q),
        .tick_o(w_tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_div_q     <= '0;
            r_bit_cnt   <= '0;
            r_bck       <= 1'b0;
            r_lrck      <= 1'b0;
            r_bck_fall  <= 1'b0;
            r_frame     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_bck_fall <= 1'b0;
            r_frame    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_bck  <= 1'b0;
                    r_lrck <= 1'b0;
                    if (en_i) begin
                        r_div_q   <= div_i;
                        r_bit_cnt <= '0;
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (r_state == RUN && !en_i) begin
                        r_state <= STOP;
                    end else if (r_state == STOP && en_i) begin
                        r_state <= RUN;
                    end
                    if (w_tick) begin
                        r_bck <= ~r_bck;
                        // lrck and bit position advance only on falling bck
                        if (r_bck) begin
                            r_bck_fall <= 1'b1;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_bit_cnt <= '0;
                                r_lrck    <= ~r_lrck;
                                if (r_lrck) begin
                                    r_frame     <= 1'b1;
                                    r_frame_cnt <= r_frame_cnt + 1'b1;
                                    r_div_q     <= div_i;
                                    if (r_state == STOP && !en_i) begin
                                        r_state <= IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bck_o       = r_bck;
    assign lrck_o      = r_lrck;
    assign bck_fall_o  = r_bck_fall;
    assign frame_o     = r_frame;
    assign busy_o      = r_busy;
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: doc/i2s_master_ctrl_module.md
Name: i2s_master_ctrl_module

Overview:
Generates the I2S bit clock and word-select (bck/lrck) from the system clock for the I2S receiver when the codec runs as a slave. A programmable divider sets the bit-clock rate; a small FSM starts and stops the bus cleanly on frame boundaries. Provides strobes and a frame counter so downstream logic knows when a fresh left/right pair is available.

Parameters:
FRAME_RES, 32, bck periods per channel slot (one lrck half-period); power of two, >= 2
DIV_RES, 8, width of the half-period divider value
FCNT_RES, 16, width of the frame counter

Ports:
clk_i  input  1  system clock; all logic on posedge
rst_i  input  1  asynchronous, active-high reset
en_i  input  1  level; 1 = run the bus, 0 = stop at the next frame boundary
div_i  input  DIV_RES  bck half-period in clk_i cycles, minus 1
bck_o  output  1  generated I2S bit clock (registered)
lrck_o  output  1  word select: 0 = left slot, 1 = right slot (registered)
bck_fall_o  output  1  one-cycle strobe, same cycle bck_o goes 1->0
frame_o  output  1  one-cycle strobe at end of each full L+R frame
busy_o  output  1  1 while state != IDLE
frame_cnt_o  output  FCNT_RES  completed-frame count, wraps modulo 2^FCNT_RES

Behaviour:
- Reset (async, rst_i=1): state=IDLE; bck_o=0, lrck_o=0, bck_fall_o=0, frame_o=0, busy_o=0, frame_cnt_o=0; internal hcnt=0, bit_cnt=0, div_q=0.
- FSM states: IDLE, RUN, STOP.
- IDLE: bck_o=0, lrck_o=0. On en_i=1: latch div_q<=div_i, hcnt<=0, bit_cnt<=0, go to RUN. busy_o=1 from the next cycle.
- Half-period timing (RUN and STOP): hcnt counts 0..div_q. When hcnt==div_q: toggle bck_o and reset hcnt to 0; otherwise hcnt+1. With div_i=0, bck_o = clk_i/2. bck_o period = 2*(div_q+1) clk_i cycles.
- First bck_o edge after leaving IDLE is rising, (div_q+1) cycles after the RUN entry cycle.
- Falling edge of bck_o (toggle 1->0):
  - bck_fall_o=1 for that cycle.
  - If bit_cnt==FRAME_RES-1: bit_cnt<=0 and lrck_o toggles. Otherwise bit_cnt+1.
  - lrck_o changes only on bck_o falling edges, so the receiver samples it stably on the rising edge.
- Frame boundary: the falling edge where bit_cnt==FRAME_RES-1 and lrck_o==1, so lrck_o goes 1->0.
  - frame_o=1 for that cycle.
  - frame_cnt_o+1, wrapping at all-ones -> 0.
  - div_q<=div_i (re-latched). The new rate takes effect from the next half-period.
  - In STOP: go to IDLE in the same update. bck_o is already 0 and lrck_o 0; hcnt and bit_cnt are cleared.
- div_i changes mid-frame are ignored until the next frame boundary.
- RUN with en_i=0: go to STOP; bus keeps running unchanged. STOP with en_i=1: return to RUN (no interruption).
- en_i=0 in the IDLE->RUN transition cycle is not possible: the transition requires en_i=1. A one-cycle en_i pulse therefore yields exactly one full frame.
- Simultaneous events: frame boundary and en_i 0->1 in STOP means en_i wins. State becomes RUN, no gap, frame_o still pulses.
- Reset mid-operation: immediate return to reset values; no partial-frame strobe.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package i2s_pkg: typedef enum logic [1:0] {IDLE, RUN, STOP} i2s_ctrl_state_t; default-value constants I2S_FRAME_RES=32 and I2S_DIV_RES=8.
- One natural sub-module: clk_div_module (DIV_RES). Ports: clk_i, rst_i, clr_i, div_i, tick_o. It produces the half-period tick. The existing cntr_module style is reused for bit_cnt ($clog2(FRAME_RES) bits).

Test Plan:
- Reset/idle: assert rst_i mid-run with div_i=3 -> all outputs 0 within the same cycle; busy_o=0, frame_cnt_o=0.
- Rate: div_i=0, en_i=1, FRAME_RES=32 -> bck_o period 2 clk; lrck_o toggles every 64 clk; frame_o every 128 clk; first frame_o at clk 128 after RUN entry; frame_cnt_o=1.
- Edge alignment: div_i=3 -> every lrck_o transition coincides with bck_fall_o=1; bck_o high and low each exactly 4 clk.
- Clean stop: drop en_i at bit 10 of the left slot -> bus continues to the frame end; frame_o pulses once; then IDLE, busy_o=0, bck_o=lrck_o=0. No further edges.
- Divider update: change div_i 1->2 mid-frame -> half-period stays 2 clk until frame_o, then becomes 3 clk.
- Wrap/restart: FCNT_RES=2, run 5 frames -> frame_cnt_o sequence 1,2,3,0,1. Re-assert en_i in the frame_o cycle during STOP -> no gap in bck_o.
